// File: rtl/phy_tx_pkg.sv
// Shared PHY transmit-path definitions: serializer state encoding and the idle/sync
// byte that the receive-side aligner also looks for.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } tx_state_t;

    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;
    localparam int         SYNC_CNT_W        = 4;

endpackage

// File: rtl/shift8_load.sv
// 8-bit parallel-load, MSB-first shift register with a 3-bit bit counter.
// A load always restarts the counter at 0; shifting fills with zeros.
module shift8_load (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic       shift_en,
    input  logic [7:0] load_data,
    output logic       msb,
    output logic [2:0] cnt
);

    logic [7:0] shift_reg;
    logic [2:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            shift_reg <= 8'd0;
            cnt_reg   <= 3'd0;
        end else if (load) begin
            shift_reg <= load_data;
            cnt_reg   <= 3'd0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            cnt_reg   <= cnt_reg + 3'd1;
        end
    end

    assign msb = shift_reg[7];
    assign cnt = cnt_reg;

endmodule

// File: rtl/par_to_serial_tx.sv
// Byte-to-bit serializer: sends SYNC_BYTES idle bytes after reset, then one byte per
// eight bit clocks, substituting the idle byte whenever upstream offers no valid data.
module par_to_serial_tx
    import phy_tx_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT,
    parameter int         SYNC_BYTES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       byte_strobe,
    output logic       data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [SYNC_CNT_W-1:0] SYNC_LAST = SYNC_CNT_W'(SYNC_BYTES);

    tx_state_t             state_reg, state_next;
    logic [SYNC_CNT_W-1:0] sync_cnt_reg;
    logic                  valid_reg;
    logic [2:0]            cnt;
    logic                  last_bit;
    logic                  final_sync;
    logic                  load;
    logic                  data_load;
    logic [7:0]            load_data;

    assign last_bit   = (cnt == 3'd7);
    assign final_sync = (sync_cnt_reg == SYNC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_SYNC;
            ST_SYNC:   if (last_bit && final_sync) state_next = ST_ACTIVE;
            ST_ACTIVE: state_next = ST_ACTIVE;
            default:   state_next = ST_RESET;
        endcase
    end

    // Data-load edges are the last sync byte boundary and every byte boundary in ACTIVE.
    always_comb begin
        load      = 1'b0;
        data_load = 1'b0;
        case (state_reg)
            ST_RESET:  load = 1'b1;
            ST_SYNC: begin
                load      = last_bit;
                data_load = last_bit && final_sync;
            end
            ST_ACTIVE: begin
                load      = last_bit;
                data_load = last_bit;
            end
            default: begin
                load      = 1'b0;
                data_load = 1'b0;
            end
        endcase
        load_data = (data_load && valid_in) ? data_in : IDLE_BYTE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_cnt_reg <= '0;
        end else if (state_reg == ST_RESET) begin
            sync_cnt_reg <= SYNC_CNT_W'(1);
        end else if (state_reg == ST_SYNC && last_bit && !final_sync) begin
            sync_cnt_reg <= sync_cnt_reg + SYNC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= data_load && valid_in;
        end
    end

    shift8_load u_shift (
        .clk       (clk),
        .srst      (reset),
        .load      (load),
        .shift_en  (state_reg != ST_RESET),
        .load_data (load_data),
        .msb       (data_out),
        .cnt       (cnt)
    );

    assign byte_strobe = data_load;
    assign valid_out   = valid_reg;
    assign active      = (state_reg == ST_ACTIVE);

endmodule

// File: tb/tb_par_to_serial_tx.sv
// Bench for par_to_serial_tx: table-driven byte slots, then random slots, checked
// per bit clock against a cycle-numbered model of the output stream.
module tb_par_to_serial_tx;

    localparam int         S    = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       byte_strobe, data_out, valid_out, active;
    logic       byte_strobe1, data_out1, valid_out1, active1;

    always #5 clk = ~clk;

    par_to_serial_tx #(.IDLE_BYTE(8'hBC), .SYNC_BYTES(S)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .byte_strobe(byte_strobe), .data_out(data_out),
        .valid_out(valid_out), .active(active)
    );

    par_to_serial_tx #(.IDLE_BYTE(8'hBC), .SYNC_BYTES(1)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .byte_strobe(byte_strobe1), .data_out(data_out1),
        .valid_out(valid_out1), .active(active1)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic [7:0] exp_byte;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[8];
    vec_t stim_q[$];
    bit   exp_bit_q[$];
    bit   exp_val_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic release_reset();
        reset = 1'b0;
        cyc = 0;
        exp_bit_q.delete();
        exp_val_q.delete();
        check("rst_data_out", data_out, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_byte_strobe", byte_strobe, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_active_s1", active1, 1'b0);
    endtask

    // One bit clock: drive inputs for the new cycle, then compare all outputs.
    task automatic step();
        logic [7:0] idle_v;
        bit   exp_strobe, exp_active, eb, ev;
        vec_t vc;
        idle_v = IDLE;
        @(posedge clk);
        #1;
        cyc++;
        exp_strobe = (cyc >= 8 * S) && ((cyc - 8 * S) % 8 == 0);
        exp_active = (cyc >= 8 * S + 1);
        eb = 1'b0;
        ev = 1'b0;
        if (cyc >= 1 && cyc <= 8 * S) begin
            eb = idle_v[7 - ((cyc - 1) % 8)];
        end else if (cyc > 8 * S) begin
            if (exp_bit_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL model_underflow cyc=%0d got=empty want=queued_bit", cyc);
            end else begin
                eb = exp_bit_q.pop_front();
                ev = exp_val_q.pop_front();
            end
        end
        if (exp_strobe) begin
            if (stim_q.size() != 0) begin
                vc = stim_q.pop_front();
            end else begin
                vc.d = 8'($urandom);
                vc.v = 1'($urandom_range(0, 1));
                vc.exp_byte = vc.v ? vc.d : IDLE;
                vc.exp_valid = vc.v;
            end
            data_in  = vc.d;
            valid_in = vc.v;
            for (int i = 7; i >= 0; i--) begin
                exp_bit_q.push_back(vc.exp_byte[i]);
                exp_val_q.push_back(vc.exp_valid);
            end
            $display("xfer cyc=%0d data_in=%h valid_in=%b expect_byte=%h expect_valid=%b",
                     cyc, vc.d, vc.v, vc.exp_byte, vc.exp_valid);
        end else begin
            data_in  = 8'($urandom);
            valid_in = 1'($urandom_range(0, 1));
        end
        check("data_out", data_out, eb);
        check("valid_out", valid_out, ev);
        check("byte_strobe", byte_strobe, exp_strobe);
        check("active", active, exp_active);
        check("byte_strobe_s1", byte_strobe1, (cyc >= 8) && (cyc % 8 == 0));
        check("active_s1", active1, cyc >= 9);
    endtask

    initial begin
        vecs[0] = '{d: 8'hA5, v: 1'b1, exp_byte: 8'hA5, exp_valid: 1'b1};
        vecs[1] = '{d: 8'hFF, v: 1'b1, exp_byte: 8'hFF, exp_valid: 1'b1};
        vecs[2] = '{d: 8'h00, v: 1'b1, exp_byte: 8'h00, exp_valid: 1'b1};
        vecs[3] = '{d: 8'h81, v: 1'b1, exp_byte: 8'h81, exp_valid: 1'b1};
        vecs[4] = '{d: 8'h3C, v: 1'b1, exp_byte: 8'h3C, exp_valid: 1'b1};
        vecs[5] = '{d: 8'h3C, v: 1'b0, exp_byte: 8'hBC, exp_valid: 1'b0};
        vecs[6] = '{d: 8'h3C, v: 1'b1, exp_byte: 8'h3C, exp_valid: 1'b1};
        vecs[7] = '{d: 8'h5A, v: 1'b0, exp_byte: 8'hBC, exp_valid: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        release_reset();

        for (int i = 0; i < 8; i++) stim_q.push_back(vecs[i]);
        repeat (8 * S + 8 * 8 + 8) step();

        repeat (200) step();

        // Reset pulse landing mid-byte: three bits into a data byte.
        for (int k = 0; k < 16; k++) begin
            if (cyc > 8 * S && (cyc - 8 * S) % 8 == 3) break;
            step();
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_data_out", data_out, 1'b0);
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_byte_strobe", byte_strobe, 1'b0);
        check("midrst_active", active, 1'b0);
        release_reset();

        stim_q.push_back(vecs[0]);
        repeat (8 * S + 80) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
